// File: rtl/logs_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : logs_sweep_ctrl
// Brief    : Steps the logistic-map growth parameter r per iteration count,
//            dwelling on periodic windows and muting while settling after wrap.
// Revision : 1.0 - initial release
// ============================================================================
module logs_sweep_ctrl #(
    parameter int FRAC         = 8,
    parameter int N_OSC        = 4,
    parameter int R_INC        = 1000,
    parameter int DWELL_MULT   = 4,
    parameter int SETTLE_ITERS = 64,
    parameter int STEP_LO      = 4,
    parameter int STEP_HI      = 1,
    parameter int R_INIT       = (1 << FRAC) | (1 << (FRAC - 4))
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          iter_done,
    input  logic                                          hold,
    output logic [FRAC+1:0]                               r,
    output logic                                          r_step,
    output logic [((N_OSC > 1) ? $clog2(N_OSC) : 1)-1:0]  n_osc_m1,
    output logic [N_OSC-1:0]                              osc_mask,
    output logic                                          mute
);

    localparam int RW            = FRAC + 2;
    localparam int NW            = (N_OSC > 1) ? $clog2(N_OSC) : 1;
    localparam int C_DWELL_ITERS = DWELL_MULT * R_INC;
    localparam int C_CNT_MAX0    = (C_DWELL_ITERS > R_INC) ? C_DWELL_ITERS : R_INC;
    localparam int C_CNT_MAX     = (SETTLE_ITERS > C_CNT_MAX0) ? SETTLE_ITERS : C_CNT_MAX0;
    localparam int CNT_W         = $clog2(C_CNT_MAX + 1);
    localparam int C_N6          = (N_OSC < 6) ? N_OSC : 6 * (N_OSC / 6);
    localparam int C_N5          = (N_OSC < 5) ? N_OSC : 5 * (N_OSC / 5);

    localparam logic [RW-1:0]    C_R_INIT      = RW'(R_INIT);
    localparam logic [CNT_W-1:0] C_RAMP_LAST   = CNT_W'(R_INC - 1);
    localparam logic [CNT_W-1:0] C_DWELL_LAST  = CNT_W'(C_DWELL_ITERS - 1);
    localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(SETTLE_ITERS - 1);
    localparam logic [N_OSC:0]   C_ONE         = (N_OSC + 1)'(1);
    localparam logic [N_OSC-1:0] C_MASK6       = N_OSC'((C_ONE << C_N6) - C_ONE);
    localparam logic [N_OSC-1:0] C_MASK5       = N_OSC'((C_ONE << C_N5) - C_ONE);

    typedef enum logic [1:0] {
        ST_RAMP   = 2'd0,
        ST_DWELL  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    // Window identity from the top eight bits of r: 0 none, 1 W6a, 2 W6b, 3 W5.
    function automatic logic [1:0] win_id(input logic [7:0] top);
        if (top == 8'b11_101000)
            return 2'd1;
        if (top[7:2] == 6'b11_1101 && top[1:0] != 2'b11)
            return 2'd2;
        if (top[7:1] == 7'b11_10111)
            return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [NW-1:0] cfg_n(input logic [1:0] id);
        case (id)
            2'd1, 2'd2: return NW'(C_N6 - 1);
            2'd3:       return NW'(C_N5 - 1);
            default:    return NW'(N_OSC - 1);
        endcase
    endfunction

    function automatic logic [N_OSC-1:0] cfg_mask(input logic [1:0] id);
        case (id)
            2'd1, 2'd2: return C_MASK6;
            2'd3:       return C_MASK5;
            default:    return '1;
        endcase
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [RW-1:0]     r_r;
    logic [RW-1:0]     w_r_nxt;
    logic              r_mute;
    logic              w_mute_nxt;
    logic              r_rstep;
    logic              w_do_step;
    logic [NW-1:0]     r_n_osc_m1;
    logic [N_OSC-1:0]  r_osc_mask;

    logic              w_ev;
    logic [RW:0]       w_inc;
    logic [RW:0]       w_sum;
    logic [RW-1:0]     w_r_inc;
    logic              w_r_max;
    logic [1:0]        w_win_cur;
    logic [1:0]        w_win_inc;
    logic [1:0]        w_win_nxt;
    logic              w_enter;

    assign w_ev    = iter_done & ~hold;
    assign w_inc   = (r_r[FRAC+1:FRAC] == 2'b11) ? (RW + 1)'(STEP_HI) : (RW + 1)'(STEP_LO);
    assign w_sum   = {1'b0, r_r} + w_inc;
    // Saturating add so every wrap first lands on all-ones.
    assign w_r_inc = w_sum[RW] ? {RW{1'b1}} : w_sum[RW-1:0];
    assign w_r_max = &r_r;

    assign w_win_cur = win_id(r_r[FRAC+1:FRAC-6]);
    assign w_win_inc = win_id(w_r_inc[FRAC+1:FRAC-6]);
    assign w_win_nxt = win_id(w_r_nxt[FRAC+1:FRAC-6]);
    assign w_enter   = (w_win_inc != 2'd0) && (w_win_inc != w_win_cur);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_r_nxt     = r_r;
        w_mute_nxt  = r_mute;
        w_do_step   = 1'b0;
        if (w_ev) begin
            case (r_state)
                ST_RAMP: begin
                    if (r_cnt == C_RAMP_LAST) begin
                        w_cnt_nxt = '0;
                        w_do_step = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_DWELL: begin
                    if (r_cnt == C_DWELL_LAST) begin
                        w_cnt_nxt = '0;
                        w_do_step = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == C_SETTLE_LAST) begin
                        w_cnt_nxt   = '0;
                        w_mute_nxt  = 1'b0;
                        w_state_nxt = ST_RAMP;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_RAMP;
                end
            endcase
        end
        if (w_do_step) begin
            if (w_r_max) begin
                w_r_nxt     = C_R_INIT;
                w_mute_nxt  = 1'b1;
                w_state_nxt = ST_SETTLE;
            end else begin
                w_r_nxt     = w_r_inc;
                w_state_nxt = w_enter ? ST_DWELL : ST_RAMP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RAMP;
            r_cnt      <= '0;
            r_r        <= C_R_INIT;
            r_mute     <= 1'b0;
            r_rstep    <= 1'b0;
            r_n_osc_m1 <= cfg_n(win_id(C_R_INIT[FRAC+1:FRAC-6]));
            r_osc_mask <= cfg_mask(win_id(C_R_INIT[FRAC+1:FRAC-6]));
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_r        <= w_r_nxt;
            r_mute     <= w_mute_nxt;
            r_rstep    <= w_do_step;
            r_n_osc_m1 <= cfg_n(w_win_nxt);
            r_osc_mask <= cfg_mask(w_win_nxt);
        end
    end

    assign r        = r_r;
    assign r_step   = r_rstep;
    assign n_osc_m1 = r_n_osc_m1;
    assign osc_mask = r_osc_mask;
    assign mute     = r_mute;

endmodule
`default_nettype wire

// File: doc/logs_sweep_ctrl.md
# logs_sweep_ctrl

Sequencer for the logistic-map sonifier's growth parameter `r`. It counts completed map iterations and steps `r` from `R_INIT` up to its maximum. It dwells on designated periodic windows and, on wrap-around, mutes the mixer while the map settles. For every value of `r` it also configures how many oscillators are active.

## Interface

Parameters:
- `FRAC`, 8: fractional bits of `r`; `r` is unsigned 2.FRAC.
- `N_OSC`, 4: number of oscillators.
- `R_INC`, 1000: iterations per `r` step.
- `DWELL_MULT`, 4: a dwell lasts `DWELL_MULT*R_INC` iterations.
- `SETTLE_ITERS`, 64: muted iterations after wrap.
- `STEP_LO`, 4: increment while `r[FRAC+1:FRAC]` < 2'b11.
- `STEP_HI`, 1: increment while `r[FRAC+1:FRAC]` == 2'b11.
- `R_INIT`, `(1<<FRAC)|(1<<(FRAC-4))`: start and wrap value of `r`.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high reset.
- `iter_done`, in, 1: one-cycle pulse per new `x` from the map iterator.
- `hold`, in, 1: while high, `iter_done` is ignored; all state is frozen.
- `r`, out, FRAC+2: current `r`, registered.
- `r_step`, out, 1: one-cycle pulse on the cycle `r` takes a new value.
- `n_osc_m1`, out, clog2(N_OSC): active oscillator count minus one, registered.
- `osc_mask`, out, N_OSC: active-oscillator mask for the mixer, registered.
- `mute`, out, 1: high while settling, registered.

## Operation

- **Event.** An event `ev` = `iter_done & ~hold`. All counting happens only on `ev`.
- **States.** RAMP, DWELL, SETTLE. One iteration counter `cnt` covers all three states.
- **RAMP.**
  - On `ev`: if `cnt == R_INC-1`, a step occurs and `cnt` returns to 0. Otherwise `cnt` increments.
- **Step rule.**
  - If `r` is all-ones: `r <= R_INIT`, go to SETTLE, `mute <= 1`.
  - Otherwise `r <= min(r + inc, all-ones)`, where `inc` = STEP_LO or STEP_HI according to the current `r`. The clamp guarantees every wrap passes through all-ones.
  - If the new `r` lies in a window and the old `r` did not, go to DWELL.
- **DWELL.**
  - On `ev`: `cnt` counts to `DWELL_MULT*R_INC-1`.
  - At that count, apply the step rule, reset `cnt`, and go to RAMP (or to DWELL/SETTLE as the step rule dictates).
  - Re-entering a window from inside the same window never dwells.
- **SETTLE.**
  - `r` is held at `R_INIT`.
  - On `ev`: `cnt` counts to `SETTLE_ITERS-1`. At that count: `mute <= 0`, `cnt <= 0`, go to RAMP. No `r` step occurs at this exit.
- **Windows** (all bit fields are of `r`):
  - W6a: `r[FRAC+1:FRAC-6]` == 8'b11_101000.
  - W6b: `r[FRAC+1:FRAC-4]` == 6'b11_1101 and `r[FRAC-5:FRAC-6]` != 2'b11.
  - W5: `r[FRAC+1:FRAC-5]` == 7'b11_10111.
- **Oscillator configuration.**
  - N6 = N_OSC<6 ? N_OSC : 6*(N_OSC/6); N5 is defined the same way with 5.
  - W6a or W6b: `n_osc_m1 = N6-1`, `osc_mask` = low N6 bits set.
  - W5: `n_osc_m1 = N5-1`, `osc_mask` = low N5 bits set.
  - Otherwise: `n_osc_m1 = N_OSC-1`, `osc_mask` = all ones.
  - Configuration is computed from the next `r` and registered on the same edge as `r`.
- **Reset values.**
  - State RAMP, `cnt` = 0, `mute` = 0, `r_step` = 0.
  - `r = R_INIT`, with `n_osc_m1`/`osc_mask` matching `R_INIT`.
- Reset has priority over everything. A reset mid-dwell or mid-settle aborts immediately with no residual state.

## Timing

- `r`, `n_osc_m1`, `osc_mask`, `mute` and `r_step` all update on the clock edge that samples the qualifying `ev`, so they are valid the next cycle.
- `r_step` is high for exactly one cycle per `r` change, including the wrap to `R_INIT`.
- `ev` with `hold` high has no effect, even on the terminal count.
- Back-to-back `iter_done` pulses on consecutive cycles must each be counted.

## Test plan

Settings for all scenarios: FRAC=8, N_OSC=8, R_INC=4, DWELL_MULT=2, SETTLE_ITERS=3.

1. Reset with R_INIT=0x110 → `r`=0x110, `n_osc_m1`=7, `osc_mask`=0xFF, `mute`=0, `r_step`=0. Then 4 `ev` → `r`=0x114 with one `r_step` pulse; 4 more → 0x118.
2. R_INIT=0x39F, 4 `ev` → `r`=0x3A0, DWELL, `n_osc_m1`=5, `osc_mask`=0x3F. The next 7 `ev` leave `r` unchanged; the 8th → `r`=0x3A1 with no new dwell. Four more `ev` → 0x3A2.
3. R_INIT=0x3B7, 4 `ev` → `r`=0x3B8, DWELL, `n_osc_m1`=4, `osc_mask`=0x1F.
4. R_INIT=0x3FE:
   - 4 `ev` → 0x3FF, default configuration.
   - 4 more `ev` → `r`=0x3FE, `mute`=1, `r_step` pulse.
   - After 3 `ev`, `mute`=0 and `r` is still 0x3FE.
   - 4 more `ev` → 0x3FF.
5. `hold`=1 with 10 `iter_done` pulses → no change. Release `hold`, then 4 `ev` → one step.
6. Reset asserted after 5 `ev` of a dwell, or during SETTLE → next cycle `r`=R_INIT, `mute`=0, default configuration. Exactly 4 `ev` are then needed for the next step.
